// File: rtl/upsample_nn_if.sv
// Shared feature type and the valid/ready feature stream used across the MNIST pipeline.
package mnist_pkg;
    typedef logic [7:0] feature_type;
endpackage

interface feature_if #(
    parameter int unsigned N = 1
);
    logic                     valid;
    logic                     ready;
    mnist_pkg::feature_type   features [N];

    modport source (output valid, output features, input ready);
    modport sink   (input valid, input features, output ready);
endinterface

// File: rtl/upsample_nn.sv
// Nearest-neighbour upsampler: buffers one input row, then replays it
// ROW_STRIDE times with each feature repeated COL_STRIDE times.
module upsample_nn #(
    parameter int unsigned ROW_STRIDE = 2,
    parameter int unsigned COL_STRIDE = 2,
    parameter int unsigned OUT_HEIGHT = 28,
    parameter int unsigned OUT_WIDTH  = 28
) (
    input  logic       clock,
    input  logic       reset_n,
    feature_if.sink    features_in,
    feature_if.source  features_out,
    output logic       frame_done
);
    localparam int unsigned IN_HEIGHT = OUT_HEIGHT / ROW_STRIDE;
    localparam int unsigned IN_WIDTH  = OUT_WIDTH / COL_STRIDE;

    localparam int unsigned COL_W  = (IN_WIDTH > 1)   ? $clog2(IN_WIDTH)   : 1;
    localparam int unsigned ROW_W  = (IN_HEIGHT > 1)  ? $clog2(IN_HEIGHT)  : 1;
    localparam int unsigned CREP_W = (COL_STRIDE > 1) ? $clog2(COL_STRIDE) : 1;
    localparam int unsigned RREP_W = (ROW_STRIDE > 1) ? $clog2(ROW_STRIDE) : 1;

    localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(IN_WIDTH - 1);
    localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(IN_HEIGHT - 1);
    localparam logic [CREP_W-1:0] CREP_LAST = CREP_W'(COL_STRIDE - 1);
    localparam logic [RREP_W-1:0] RREP_LAST = RREP_W'(ROW_STRIDE - 1);

    typedef enum logic [0:0] {S_FILL, S_EMIT} state_t;

    state_t                 state, state_next;
    logic [COL_W-1:0]       in_col, in_col_next;
    logic [ROW_W-1:0]       in_row, in_row_next;
    logic [CREP_W-1:0]      col_rep, col_rep_next;
    logic [COL_W-1:0]       buf_col, buf_col_next;
    logic [RREP_W-1:0]      row_rep, row_rep_next;
    logic                   done_next;
    logic                   wr_en;

    mnist_pkg::feature_type rowbuf [IN_WIDTH];

    // Handshake signals depend on registered state only.
    assign features_in.ready        = (state == S_FILL);
    assign features_out.valid       = (state == S_EMIT);
    assign features_out.features[0] = rowbuf[buf_col];

    // State and counter registers; all cleared asynchronously.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_FILL;
            in_col     <= '0;
            in_row     <= '0;
            col_rep    <= '0;
            buf_col    <= '0;
            row_rep    <= '0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_next;
            in_col     <= in_col_next;
            in_row     <= in_row_next;
            col_rep    <= col_rep_next;
            buf_col    <= buf_col_next;
            row_rep    <= row_rep_next;
            frame_done <= done_next;
        end
    end

    // Row buffer write; contents need no reset.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            rowbuf[in_col] <= features_in.features[0];
        end
    end

    // Next-state logic: fill one row, then walk nested replication counters.
    always_comb begin
        state_next   = state;
        in_col_next  = in_col;
        in_row_next  = in_row;
        col_rep_next = col_rep;
        buf_col_next = buf_col;
        row_rep_next = row_rep;
        done_next    = 1'b0;
        wr_en        = 1'b0;

        case (state)
            S_FILL: begin
                if (features_in.valid) begin
                    wr_en = 1'b1;
                    if (in_col == COL_LAST) begin
                        in_col_next = '0;
                        state_next  = S_EMIT;
                    end else begin
                        in_col_next = in_col + COL_W'(1);
                    end
                end
            end
            S_EMIT: begin
                if (features_out.ready) begin
                    if (col_rep != CREP_LAST) begin
                        col_rep_next = col_rep + CREP_W'(1);
                    end else begin
                        col_rep_next = '0;
                        if (buf_col != COL_LAST) begin
                            buf_col_next = buf_col + COL_W'(1);
                        end else begin
                            buf_col_next = '0;
                            if (row_rep != RREP_LAST) begin
                                row_rep_next = row_rep + RREP_W'(1);
                            end else begin
                                // Last beat of the replicated row.
                                row_rep_next = '0;
                                state_next   = S_FILL;
                                if (in_row == ROW_LAST) begin
                                    in_row_next = '0;
                                    done_next   = 1'b1;
                                end else begin
                                    in_row_next = in_row + ROW_W'(1);
                                end
                            end
                        end
                    end
                end
            end
            default: state_next = S_FILL;
        endcase
    end
endmodule

// File: tb/tb_upsample_nn.sv
// Scoreboard bench for upsample_nn: a 4x4/2x2 instance and a 2x6/1x3 instance.
module tb_upsample_nn;
    import mnist_pkg::feature_type;

    typedef struct {
        feature_type data;
        bit          last;
    } exp_t;

    logic clock;
    logic reset_n;
    logic frame_done;
    logic frame_done_a;

    feature_if in_if ();
    feature_if out_if ();
    feature_if in_a ();
    feature_if out_a ();

    upsample_nn #(
        .ROW_STRIDE(2), .COL_STRIDE(2), .OUT_HEIGHT(4), .OUT_WIDTH(4)
    ) dut (
        .clock(clock), .reset_n(reset_n), .features_in(in_if),
        .features_out(out_if), .frame_done(frame_done)
    );

    upsample_nn #(
        .ROW_STRIDE(1), .COL_STRIDE(3), .OUT_HEIGHT(2), .OUT_WIDTH(6)
    ) dut_a (
        .clock(clock), .reset_n(reset_n), .features_in(in_a),
        .features_out(out_a), .frame_done(frame_done_a)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb[$];
    exp_t sb_a[$];
    int   pops     = 0;
    int   pops_a   = 0;
    int   done_cnt = 0;
    int   done_a   = 0;
    int   done_hs  = 0;
    bit   bp_mode  = 1'b0;

    task automatic check(input bit ok, input string name, input int act, input int req);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // Downstream ready: constant 1, or the repeating pattern 1,0,0,1.
    initial begin
        bit [3:0] pat;
        int cyc;
        pat = 4'b1001;
        cyc = 0;
        out_if.ready = 1'b1;
        out_a.ready  = 1'b1;
        forever begin
            @(posedge clock);
            #1;
            out_if.ready = bp_mode ? pat[cyc % 4] : 1'b1;
            cyc++;
        end
    end

    // Monitor for the 2x2 instance.
    initial begin
        int          in_cnt;
        bit          exp_done, exp_valid, stall;
        feature_type stall_data;
        exp_t        e;
        in_cnt = 0; exp_done = 0; exp_valid = 0; stall = 0; stall_data = '0;
        forever begin
            @(negedge clock);
            if (!reset_n) begin
                in_cnt = 0; exp_done = 0; exp_valid = 0; stall = 0;
            end else begin
                check(in_if.ready == !out_if.valid, "ready_vs_valid",
                      int'(in_if.ready), int'(!out_if.valid));
                if (exp_valid) check(out_if.valid == 1'b1, "first_out_latency",
                                     int'(out_if.valid), 1);
                check(frame_done == exp_done, "frame_done", int'(frame_done), int'(exp_done));
                if (frame_done) done_cnt++;
                if (frame_done && in_if.valid && in_if.ready) done_hs++;
                if (stall && out_if.valid)
                    check(out_if.features[0] == stall_data, "hold_data",
                          int'(out_if.features[0]), int'(stall_data));
                exp_done = 0; exp_valid = 0;
                if (out_if.valid && out_if.ready) begin
                    if (sb.size() == 0) begin
                        check(1'b0, "unexpected_beat", int'(out_if.features[0]), -1);
                    end else begin
                        e = sb.pop_front();
                        check(out_if.features[0] == e.data, "out_data",
                              int'(out_if.features[0]), int'(e.data));
                        if (e.last) exp_done = 1;
                        pops++;
                    end
                end
                stall      = out_if.valid && !out_if.ready;
                stall_data = out_if.features[0];
                if (in_if.valid && in_if.ready) begin
                    if (in_cnt == 1) begin in_cnt = 0; exp_valid = 1; end
                    else in_cnt++;
                end
            end
        end
    end

    // Monitor for the asymmetric instance.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (reset_n) begin
                if (frame_done_a) done_a++;
                if (out_a.valid && out_a.ready) begin
                    if (sb_a.size() == 0) begin
                        check(1'b0, "asym_unexpected_beat", int'(out_a.features[0]), -1);
                    end else begin
                        e = sb_a.pop_front();
                        check(out_a.features[0] == e.data, "asym_out_data",
                              int'(out_a.features[0]), int'(e.data));
                        pops_a++;
                    end
                end
            end
        end
    end

    // Present one beat (called at posedge+1); returns at posedge+1 after its handshake.
    task automatic send_beat(input bit asym, input feature_type v, input bit gap);
        bit done;
        done = 0;
        if (asym) begin in_a.valid = 1'b1; in_a.features[0] = v; end
        else begin in_if.valid = 1'b1; in_if.features[0] = v; end
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clock);
            if (asym ? in_a.ready : in_if.ready) begin
                @(posedge clock);
                #1;
                done = 1;
            end
        end
        if (!done) check(1'b0, "input_accept_timeout", 0, 1);
        if (gap) begin
            if (asym) in_a.valid = 1'b0; else in_if.valid = 1'b0;
            @(posedge clock);
            #1;
        end
    endtask

    task automatic push_frame(input feature_type px [4]);
        feature_type o [16];
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                o[r*4+c] = px[(r/2)*2 + c/2];
        for (int k = 0; k < 16; k++) sb.push_back('{o[k], k == 15});
    endtask

    task automatic send_frame(input feature_type px [4], input bit gap);
        for (int k = 0; k < 4; k++) send_beat(1'b0, px[k], gap);
        in_if.valid = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 500 && (sb.size() != 0 || sb_a.size() != 0); i++) @(negedge clock);
        check(sb.size() == 0 && sb_a.size() == 0, "drain_timeout", sb.size() + sb_a.size(), 0);
        repeat (3) @(posedge clock);
        #1;
    endtask

    initial begin
        feature_type f1 [4];
        feature_type f2 [4];
        feature_type f3 [4];
        int          base;
        f1 = '{8'd1, 8'd2, 8'd3, 8'd4};
        f2 = '{8'd5, 8'd6, 8'd7, 8'd8};
        f3 = '{8'h21, 8'h22, 8'h23, 8'h24};

        in_if.valid = 1'b0; in_if.features[0] = '0;
        in_a.valid  = 1'b0; in_a.features[0]  = '0;
        reset_n = 1'b0;
        repeat (2) @(negedge clock);
        check(in_if.ready == 1'b1, "reset_ready", int'(in_if.ready), 1);
        check(out_if.valid == 1'b0, "reset_valid", int'(out_if.valid), 0);
        check(frame_done == 1'b0, "reset_frame_done", int'(frame_done), 0);
        @(posedge clock); #1;
        reset_n = 1'b1;
        @(posedge clock); #1;

        // Basic 2x2.
        push_frame(f1);
        send_frame(f1, 1'b0);
        wait_drain();
        check(done_cnt == 1, "basic_done_count", done_cnt, 1);

        // Downstream backpressure.
        bp_mode = 1'b1;
        push_frame(f1);
        send_frame(f1, 1'b0);
        wait_drain();
        bp_mode = 1'b0;
        check(done_cnt == 2, "bp_done_count", done_cnt, 2);

        // Upstream gaps.
        push_frame(f1);
        send_frame(f1, 1'b1);
        wait_drain();
        check(done_cnt == 3, "gap_done_count", done_cnt, 3);

        // Asymmetric strides.
        sb_a.push_back('{8'hA, 0}); sb_a.push_back('{8'hA, 0}); sb_a.push_back('{8'hA, 0});
        sb_a.push_back('{8'hB, 0}); sb_a.push_back('{8'hB, 0}); sb_a.push_back('{8'hB, 0});
        sb_a.push_back('{8'hC, 0}); sb_a.push_back('{8'hC, 0}); sb_a.push_back('{8'hC, 0});
        sb_a.push_back('{8'hD, 0}); sb_a.push_back('{8'hD, 0}); sb_a.push_back('{8'hD, 1});
        send_beat(1'b1, 8'hA, 1'b0);
        send_beat(1'b1, 8'hB, 1'b0);
        send_beat(1'b1, 8'hC, 1'b0);
        send_beat(1'b1, 8'hD, 1'b0);
        in_a.valid = 1'b0;
        wait_drain();
        check(pops_a == 12, "asym_beat_count", pops_a, 12);
        check(done_a == 1, "asym_done_count", done_a, 1);

        // Reset after 5 output beats.
        base = pops;
        push_frame(f1);
        send_beat(1'b0, f1[0], 1'b0);
        send_beat(1'b0, f1[1], 1'b0);
        in_if.valid = 1'b0;
        for (int i = 0; i < 100 && pops < base + 5; i++) @(negedge clock);
        check(pops == base + 5, "pre_reset_beats", pops - base, 5);
        @(posedge clock); #1;
        reset_n = 1'b0;
        sb.delete();
        @(negedge clock);
        check(in_if.ready == 1'b1, "midreset_ready", int'(in_if.ready), 1);
        check(out_if.valid == 1'b0, "midreset_valid", int'(out_if.valid), 0);
        @(posedge clock); #1;
        reset_n = 1'b1;
        @(posedge clock); #1;
        push_frame(f2);
        send_frame(f2, 1'b0);
        wait_drain();
        check(done_cnt == 4, "reset_done_count", done_cnt, 4);

        // Back-to-back frames with continuous upstream valid.
        push_frame(f2);
        push_frame(f3);
        for (int k = 0; k < 4; k++) send_beat(1'b0, f2[k], 1'b0);
        for (int k = 0; k < 4; k++) send_beat(1'b0, f3[k], 1'b0);
        in_if.valid = 1'b0;
        wait_drain();
        check(done_cnt == 6, "b2b_done_count", done_cnt, 6);
        check(done_hs == 1, "accept_in_done_cycle", done_hs, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
